rdata_hold_fifo: RTL and testbench



---
 rtl/rdata_hold_fifo.sv | 102 ++++++++++
 tb/tb_rdata_hold_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rdata_hold_fifo.sv
// rtl/rdata_hold_fifo.sv - in-order read-data hold buffer between data memory and the memory-stage register
// Optional combinational empty-buffer bypass: define RDATA_BYPASS_EN.
module rdata_hold_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_issue,
    output logic              req_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(DEPTH);

    logic              pend_q, pend_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] entry_q [DEPTH];
    logic [DATA_W-1:0] entry_d [DEPTH];

    logic buf_empty;
    logic bypass_take;
    logic push;
    logic pop;

    always_comb begin
        buf_empty   = (count_q == '0);
        // Counting pend against capacity guarantees the in-flight word always has a slot.
        req_ready   = ({1'b0, count_q} + {{CNT_W{1'b0}}, pend_q}) < DEPTH_X;
        bypass_take = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        if (!flush) begin
            if (!buf_empty) begin
                out_valid = 1'b1;
                out_data  = entry_q[rd_ptr_q];
            end
`ifdef RDATA_BYPASS_EN
            else if (pend_q) begin
                out_valid   = 1'b1;
                out_data    = mem_rdata;
                bypass_take = 1'b1;
            end
`endif
        end
        pop  = out_valid & out_ready;
        push = pend_q & ~flush & ~(bypass_take & out_ready);
    end

    always_comb begin
        pend_d   = req_issue & req_ready & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        entry_d  = entry_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                entry_d[wr_ptr_q] = mem_rdata;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: it is only visible while count is nonzero.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign count = count_q;

endmodule

// File: tb/tb_rdata_hold_fifo.sv
// tb/tb_rdata_hold_fifo.sv - directed vector bench for rdata_hold_fifo (DEPTH=2 and DEPTH=4 instances)
module tb_rdata_hold_fifo;

`ifdef RDATA_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, fl2, rq2, or2, rr2, ov2;
    logic [31:0] md2, od2;
    logic [1:0]  cnt2;

    logic        rst4, fl4, rq4, or4, rr4, ov4;
    logic [31:0] md4, od4;
    logic [2:0]  cnt4;

    rdata_hold_fifo #(.DATA_W(32), .DEPTH(2)) u2 (
        .clk(clk), .reset(rst2), .flush(fl2), .req_issue(rq2), .req_ready(rr2),
        .mem_rdata(md2), .out_ready(or2), .out_valid(ov2), .out_data(od2), .count(cnt2)
    );

    rdata_hold_fifo #(.DATA_W(32), .DEPTH(4)) u4 (
        .clk(clk), .reset(rst4), .flush(fl4), .req_issue(rq4), .req_ready(rr4),
        .mem_rdata(md4), .out_ready(or4), .out_valid(ov4), .out_data(od4), .count(cnt4)
    );

    typedef struct {
        logic        flush;
        logic        req;
        logic [31:0] mem;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  ec;
        logic        er;
    } vec_t;

    int vecs_applied = 0;
    int miscompares  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic f, input logic r, input logic [31:0] m, input logic o,
                                input logic ev, input logic [31:0] ed, input logic [2:0] ec,
                                input logic er);
        vec_t v;
        v.flush = f; v.req = r; v.mem = m; v.ordy = o;
        v.ev = ev; v.ed = ed; v.ec = ec; v.er = er;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        int   sent;
        int   recv;
        int   cyc;
        logic pend_m;
        int   pend_word;

        // Rows 0-4: single request then idle; rows 5-12: stalled fill to full, then drain.
        tbl[0]  = mk(0, 0, 32'h0,         1, 0,    32'h0,                      3'd0,      1);
        tbl[1]  = mk(0, 1, 32'h0,         1, 0,    32'h0,                      3'd0,      1);
        tbl[2]  = mk(0, 0, 32'h1234_5678, 1, BYP,  BYP ? 32'h1234_5678 : 32'h0, 3'd0,      1);
        tbl[3]  = mk(0, 0, 32'h0,         1, !BYP, !BYP ? 32'h1234_5678 : 32'h0, BYP ? 3'd0 : 3'd1, 1);
        tbl[4]  = mk(0, 0, 32'h0,         1, 0,    32'h0,                      3'd0,      1);
        tbl[5]  = mk(0, 1, 32'h0,         0, 0,    32'h0,                      3'd0,      1);
        tbl[6]  = mk(0, 1, 32'hA,         0, BYP,  BYP ? 32'hA : 32'h0,        3'd0,      1);
        tbl[7]  = mk(0, 0, 32'hB,         0, 1,    32'hA,                      3'd1,      0);
        tbl[8]  = mk(0, 1, 32'hDEAD,      0, 1,    32'hA,                      3'd2,      0);
        tbl[9]  = mk(0, 0, 32'hDEAD,      0, 1,    32'hA,                      3'd2,      0);
        tbl[10] = mk(0, 0, 32'h0,         1, 1,    32'hA,                      3'd2,      0);
        tbl[11] = mk(0, 0, 32'h0,         1, 1,    32'hB,                      3'd1,      1);
        tbl[12] = mk(0, 0, 32'h0,         1, 0,    32'h0,                      3'd0,      1);

        rst2 = 1'b1; fl2 = 1'b0; rq2 = 1'b0; or2 = 1'b1; md2 = 32'h0;
        rst4 = 1'b1; fl4 = 1'b0; rq4 = 1'b0; or4 = 1'b1; md4 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(ov2), 32'd0);
        chk("reset_data", od2, 32'h0);
        chk("reset_count", 32'(cnt2), 32'd0);
        chk("reset_ready", 32'(rr2), 32'd1);
        rst2 = 1'b0;
        rst4 = 1'b0;

        for (int i = 0; i < 13; i++) begin
            fl2 = tbl[i].flush; rq2 = tbl[i].req; md2 = tbl[i].mem; or2 = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(ov2), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_data", i), od2, tbl[i].ed);
            chk($sformatf("vec%0d_count", i), 32'(cnt2), 32'(tbl[i].ec));
            chk($sformatf("vec%0d_ready", i), 32'(rr2), 32'(tbl[i].er));
            @(posedge clk);
            #1;
        end
        rq2 = 1'b0; md2 = 32'h0;

        // Asynchronous reset mid-cycle with one word held.
        or2 = 1'b0; rq2 = 1'b1;
        @(posedge clk); #1;
        rq2 = 1'b0; md2 = 32'h77;
        @(posedge clk); #1;
        chk("prereset_count", 32'(cnt2), 32'd1);
        #2 rst2 = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ov2), 32'd0);
        chk("async_rst_data", od2, 32'h0);
        chk("async_rst_count", 32'(cnt2), 32'd0);
        chk("async_rst_ready", 32'(rr2), 32'd1);
        @(posedge clk); #1;
        rst2 = 1'b0; or2 = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(ov2), 32'd0);

        // Flush in the response cycle with two words held and one in flight.
        or4 = 1'b0; rq4 = 1'b1; md4 = 32'h0;
        @(posedge clk); #1;
        md4 = 32'h1;
        @(posedge clk); #1;
        md4 = 32'h2;
        @(negedge clk);
        chk("flush_pre_ready", 32'(rr4), 32'd1);
        @(posedge clk); #1;
        rq4 = 1'b1; md4 = 32'h3; fl4 = 1'b1;
        @(negedge clk);
        chk("flush_count_before", 32'(cnt4), 32'd2);
        chk("flush_valid", 32'(ov4), 32'd0);
        chk("flush_data", od4, 32'h0);
        @(posedge clk); #1;
        fl4 = 1'b0; rq4 = 1'b0; or4 = 1'b1;
        @(negedge clk);
        chk("flush_count_after", 32'(cnt4), 32'd0);
        chk("flush_valid_after", 32'(ov4), 32'd0);
        chk("flush_ready_after", 32'(rr4), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_word_dropped", 32'(ov4), 32'd0);
        @(posedge clk); #1;

        // 20 words through DEPTH=4 with the stall toggling every 3 cycles.
        sent = 0; recv = 0; cyc = 0; pend_m = 1'b0; pend_word = 0;
        while (recv < 20 && cyc < 400) begin
            or4 = (((cyc / 3) % 2) == 0);
            md4 = pend_m ? 32'(pend_word) : 32'hBAD0_BAD0;
            rq4 = (sent < 20);
            @(negedge clk);
            if (ov4 && or4) begin
                chk("stream_word", od4, 32'(recv));
                recv++;
            end
            pend_m = rq4 && rr4;
            if (pend_m) begin
                pend_word = sent;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("stream_received", 32'(recv), 32'd20);
        rq4 = 1'b0; or4 = 1'b1; md4 = 32'h0;
        @(negedge clk);
        chk("stream_final_count", 32'(cnt4), 32'd0);
        chk("stream_final_valid", 32'(ov4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs_applied, miscompares);
        $finish;
    end

endmodule
